pulse_evt_arb_dst: RTL

//   Destination-domain controller for NCH toggle-based pulse CDC channels. Synchronizes each toggle

---
 rtl/pulse_evt_arb_dst_if.sv | 24 ++
 rtl/pulse_evt_arb_dst.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_evt_arb_dst_if.sv
// -----------------------------------------------------------------------------
// pulse_evt_arb_dst_if
//   Valid/ready event port between the pulse-CDC destination controller and
//   its single consumer in the clk_dst domain.
//
//   Signals
//     evt_valid  master->slave  event presented
//     evt_ready  slave->master  consumer accepts the presented event
//     evt_id     master->slave  channel number of the presented event
//
//   Modports
//     master  the event source (pulse_evt_arb_dst)
//     slave   the event consumer
// -----------------------------------------------------------------------------
interface pulse_evt_arb_dst_if #(
  parameter int ID_W = 2
) ();
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;

  modport master (output evt_valid, output evt_id, input  evt_ready);
  modport slave  (input  evt_valid, input  evt_id, output evt_ready);
endinterface : pulse_evt_arb_dst_if

// File: rtl/pulse_evt_arb_dst.sv
// -----------------------------------------------------------------------------
// pulse_evt_arb_dst
//   Destination-domain controller for NCH toggle-based pulse CDC channels.
//   Each toggle line is synchronized into clk_dst. Every level change becomes
//   one event, which is queued in a saturating per-channel pending counter.
//   A round-robin arbiter serializes the pending events onto one valid/ready
//   port that carries the channel ID.
//
//   Ports
//     clk_dst   in   1     destination clock
//     rst_n     in   1     asynchronous active-low reset
//     tq_in     in   NCH   toggle lines from the source domain (asynchronous)
//     evt       master     valid/ready event port (evt_valid, evt_ready, evt_id)
//     ovf       out  NCH   sticky overflow: an event was lost on a saturated counter
//     ovf_clr   in   NCH   one-cycle clear pulse per overflow flag
//     pend_any  out  1     some pending counter is nonzero
//     ack       out  NCH   synchronized toggle level back to the source
//                          (present only when ACK_RETURN_EN is defined)
//
//   Build option
//     ACK_RETURN_EN  when defined, adds the ack port for handshake-mode
//                    sources that wait for ack[i] to match their toggle level.
// -----------------------------------------------------------------------------
module pulse_evt_arb_dst #(
  parameter int NCH         = 4,
  parameter int CNT_W       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = $clog2(NCH)
) (
  input  logic                   clk_dst,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         tq_in,
  pulse_evt_arb_dst_if.master    evt,
  output logic [NCH-1:0]         ovf,
  input  logic [NCH-1:0]         ovf_clr,
  output logic                   pend_any
`ifdef ACK_RETURN_EN
  ,
  output logic [NCH-1:0]         ack
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer and toggle-to-event conversion
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0] hist_q;
  logic [NCH-1:0] edge_det;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the
  // synchronizer chain into a single stage.
  always_ff @(posedge clk_dst or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= tq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // History resets to 0, so a line already high at reset release yields
  // exactly one event.
  assign edge_det = sync_q[SYNC_STAGES-1] ^ hist_q;

`ifdef ACK_RETURN_EN
  // The last synchronizer stage is already a clk_dst register.
  assign ack = sync_q[SYNC_STAGES-1];
`endif

  // ---------------------------------------------------------------------------
  // Pending counters and overflow flags
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [NCH-1:0]   cnt_nz;
  logic [NCH-1:0]   inc;
  logic [NCH-1:0]   dec;
  logic [NCH-1:0]   ovf_set;

  state_t          state_q, state_d;
  logic [ID_W-1:0] evt_id_q, evt_id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            evt_valid;
  logic            accept;

  assign evt_valid = (state_q == ST_PRESENT);
  assign accept    = evt_valid && evt.evt_ready;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    inc     = '0;
    dec     = '0;
    ovf_set = '0;
    cnt_nz  = '0;
    for (int i = 0; i < NCH; i++) begin
      inc[i]     = edge_det[i];
      dec[i]     = accept && (evt_id_q == ID_W'(i));
      cnt_nz[i]  = (cnt_q[i] != '0);
      // A simultaneous accept frees the slot the new event needs, so only an
      // unmatched increment at saturation loses an event.
      ovf_set[i] = inc[i] && !dec[i] && (cnt_q[i] == CNT_MAX);
    end
  end

  // NOTE: the counter array is a small register file of control state, not a
  // RAM, so every entry is reset; a pending count must never survive reset.
  always_ff @(posedge clk_dst or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (inc[i] && !dec[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (dec[i] && !inc[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  // A new overflow wins over a clear arriving in the same cycle.
  always_ff @(posedge clk_dst or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= '0;
    end else begin
      ovf <= ovf_set | (ovf & ~ovf_clr);
    end
  end

  assign pend_any = |cnt_nz;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first nonzero counter scanning upward from rr_ptr+1.
  // ---------------------------------------------------------------------------
  logic            pick_vld;
  logic [ID_W-1:0] pick_id;
  int              scan_idx;

  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    scan_idx = 0;
    for (int k = 1; k <= NCH; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NCH;
      if (!pick_vld && cnt_nz[scan_idx]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(scan_idx);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Presentation FSM. The presented event stays counted until accepted, and
  // the IDLE cycle after each accept caps throughput at one event per two
  // cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_dst or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      evt_id_q <= '0;
      rr_ptr_q <= ID_W'(NCH - 1);
    end else begin
      state_q  <= state_d;
      evt_id_q <= evt_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    evt_id_d = evt_id_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          evt_id_d = pick_id;
          state_d  = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (evt.evt_ready) begin
          rr_ptr_d = evt_id_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign evt.evt_valid = evt_valid;
  assign evt.evt_id    = evt_id_q;

endmodule : pulse_evt_arb_dst
